// File: rtl/instr_fetch_unit.sv
// Program counter, loadable instruction store and LOAD/RUN/HALT run control for the 8-bit CPU.
// Optional PC range trap enabled by defining PC_WRAP_TRAP_EN.
module instr_fetch_unit #(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 8
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Load_En,
  input  logic [ADDR_W-1:0]  Load_Addr,
  input  logic [INSTR_W-1:0] Load_Data,
  input  logic               Start,
  input  logic               Halt_Req,
  input  logic               Branch_Taken,
  input  logic [7:0]         Sign_Extended_Value,
  output logic [ADDR_W-1:0]  PC,
  output logic [INSTR_W-1:0] Instr_Code,
  output logic               Running,
  output logic               Halted,
  output logic [7:0]         Instr_Count,
  output logic               Fault
);
  // state | meaning
  // LOAD  | program may be written, core idle
  // RUN   | fetching and retiring one instruction per cycle
  // HALT  | stopped after Halt_Req or a PC range fault; program may be written
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_HALT} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [INSTR_W-1:0]  mem_q [DEPTH];
  logic                mem_we;
  logic [7:0]          target;

  assign mem_we = Load_En && (state_q != ST_RUN);

  // Program store is deliberately not reset so it survives Reset_n.
  always_ff @(posedge Clk) begin
    if (mem_we) mem_q[Load_Addr] <= Load_Data;
  end

  assign target = 8'(pc_q) + 8'd1 + (Branch_Taken ? Sign_Extended_Value : 8'd0);

`ifdef PC_WRAP_TRAP_EN
  logic fault_q, fault_d, range_err;
  assign range_err = |target[7:ADDR_W];
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) fault_q <= 1'b0;
    else          fault_q <= fault_d;
  end
  assign Fault = fault_q;
`else
  logic unused_target_hi;
  assign unused_target_hi = ^target[7:ADDR_W];
  assign Fault = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_LOAD;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
`ifdef PC_WRAP_TRAP_EN
    fault_d = fault_q;
`endif
    case (state_q)
      ST_LOAD: begin
        if (Start) begin
          state_d = ST_RUN;
          pc_d    = '0;
          cnt_d   = '0;
`ifdef PC_WRAP_TRAP_EN
          fault_d = 1'b0;
`endif
        end
      end
      ST_RUN: begin
        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        // Halt wins over branch; the halting instruction still retires.
        if (Halt_Req) state_d = ST_HALT;
`ifdef PC_WRAP_TRAP_EN
        else if (range_err) begin
          fault_d = 1'b1;
          state_d = ST_HALT;
        end
`endif
        else pc_d = target[ADDR_W-1:0];
      end
      ST_HALT: begin
        if (Start) begin
          state_d = ST_RUN;
          pc_d    = '0;
          cnt_d   = '0;
`ifdef PC_WRAP_TRAP_EN
          fault_d = 1'b0;
`endif
        end else if (Load_En) begin
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_comb begin
    Running    = (state_q == ST_RUN);
    Halted     = (state_q == ST_HALT);
    Instr_Code = (state_q == ST_RUN) ? mem_q[pc_q] : '0;
  end

  assign PC          = pc_q;
  assign Instr_Count = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, randomized run against a behavioural model,
// and hand sequences for saturation, PC wrap/trap (PC_WRAP_TRAP_EN) and mid-run reset.
module tb_instr_fetch_unit;
  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       le = 1'b0;
  logic [3:0] la = '0;
  logic [7:0] ld = '0;
  logic       st = 1'b0, hr = 1'b0, bt = 1'b0;
  logic [7:0] sev = '0;
  logic [3:0] PC;
  logic [7:0] Instr_Code, Instr_Count;
  logic       Running, Halted, Fault;

  int errors = 0;
  int checks = 0;

  instr_fetch_unit #(.ADDR_W(4), .INSTR_W(8)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Load_En(le), .Load_Addr(la), .Load_Data(ld),
    .Start(st), .Halt_Req(hr), .Branch_Taken(bt), .Sign_Extended_Value(sev),
    .PC(PC), .Instr_Code(Instr_Code), .Running(Running), .Halted(Halted),
    .Instr_Count(Instr_Count), .Fault(Fault)
  );

  always #5 Clk = ~Clk;

  // Behavioural model: 0=LOAD 1=RUN 2=HALT
  int         m_state, m_pc, m_cnt, m_fault;
  logic [7:0] m_mem [16];

  task automatic model_reset();
    m_state = 0; m_pc = 0; m_cnt = 0; m_fault = 0;
  endtask

  task automatic model_step();
    int s, t;
    case (m_state)
      0: begin
        if (le) m_mem[la] = ld;
        if (st) begin m_state = 1; m_pc = 0; m_cnt = 0; m_fault = 0; end
      end
      1: begin
        if (m_cnt < 255) m_cnt++;
        s = (sev > 8'd127) ? int'(sev) - 256 : int'(sev);
        t = m_pc + 1 + (bt ? s : 0);
        if (hr) m_state = 2;
`ifdef PC_WRAP_TRAP_EN
        else if (t < 0 || t > 15) begin m_fault = 1; m_state = 2; end
`endif
        else m_pc = t & 15;
      end
      default: begin
        if (le) m_mem[la] = ld;
        if (st) begin m_state = 1; m_pc = 0; m_cnt = 0; m_fault = 0; end
        else if (le) m_state = 0;
      end
    endcase
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model(string tag);
    chk({tag, " pc"}, 32'(PC), 32'(m_pc));
    chk({tag, " instr"}, 32'(Instr_Code), (m_state == 1) ? 32'(m_mem[m_pc]) : 32'd0);
    chk({tag, " running"}, 32'(Running), 32'(m_state == 1));
    chk({tag, " halted"}, 32'(Halted), 32'(m_state == 2));
    chk({tag, " count"}, 32'(Instr_Count), 32'(m_cnt));
    chk({tag, " fault"}, 32'(Fault), 32'(m_fault));
  endtask

  task automatic cycle();
    @(posedge Clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    le = 1'b0; st = 1'b0; hr = 1'b0; bt = 1'b0; sev = '0;
  endtask

  typedef struct {
    logic le; logic [3:0] la; logic [7:0] ld; logic st, hr, bt; logic [7:0] sev;
    logic [3:0] pc; logic [7:0] ic; logic run, hlt; logic [7:0] cnt;
  } vec_t;

  vec_t tbl [24];

  initial begin
    //          le la     ld      st hr bt sev     pc     ic      run hlt cnt
    tbl[0]  = '{1, 4'd0, 8'h11, 0, 0, 0, 8'h00, 4'd0, 8'h00, 0, 0, 8'd0};
    tbl[1]  = '{1, 4'd1, 8'h22, 0, 0, 0, 8'h00, 4'd0, 8'h00, 0, 0, 8'd0};
    tbl[2]  = '{1, 4'd2, 8'h33, 0, 0, 0, 8'h00, 4'd0, 8'h00, 0, 0, 8'd0};
    tbl[3]  = '{1, 4'd3, 8'h44, 1, 0, 0, 8'h00, 4'd0, 8'h11, 1, 0, 8'd0};
    tbl[4]  = '{0, 4'd0, 8'h00, 0, 0, 0, 8'h00, 4'd1, 8'h22, 1, 0, 8'd1};
    tbl[5]  = '{0, 4'd0, 8'h00, 0, 0, 0, 8'h00, 4'd2, 8'h33, 1, 0, 8'd2};
    tbl[6]  = '{0, 4'd0, 8'h00, 0, 0, 0, 8'h00, 4'd3, 8'h44, 1, 0, 8'd3};
    tbl[7]  = '{0, 4'd0, 8'h00, 0, 0, 0, 8'h00, 4'd4, 8'hA4, 1, 0, 8'd4};
    tbl[8]  = '{0, 4'd0, 8'h00, 0, 0, 1, 8'hFB, 4'd0, 8'h11, 1, 0, 8'd5};
    tbl[9]  = '{0, 4'd0, 8'h00, 0, 0, 0, 8'h00, 4'd1, 8'h22, 1, 0, 8'd6};
    tbl[10] = '{0, 4'd0, 8'h00, 0, 0, 0, 8'h00, 4'd2, 8'h33, 1, 0, 8'd7};
    tbl[11] = '{0, 4'd0, 8'h00, 0, 0, 1, 8'hFD, 4'd0, 8'h11, 1, 0, 8'd8};
    tbl[12] = '{0, 4'd0, 8'h00, 0, 0, 0, 8'h00, 4'd1, 8'h22, 1, 0, 8'd9};
    tbl[13] = '{0, 4'd0, 8'h00, 0, 0, 0, 8'h00, 4'd2, 8'h33, 1, 0, 8'd10};
    tbl[14] = '{0, 4'd0, 8'h00, 0, 0, 1, 8'h02, 4'd5, 8'hA5, 1, 0, 8'd11};
    tbl[15] = '{0, 4'd0, 8'h00, 0, 0, 0, 8'h00, 4'd6, 8'hA6, 1, 0, 8'd12};
    tbl[16] = '{0, 4'd0, 8'h00, 0, 1, 1, 8'h05, 4'd6, 8'h00, 0, 1, 8'd13};
    tbl[17] = '{1, 4'd6, 8'h5A, 0, 0, 0, 8'h00, 4'd6, 8'h00, 0, 0, 8'd13};
    tbl[18] = '{0, 4'd0, 8'h00, 1, 0, 0, 8'h00, 4'd0, 8'h11, 1, 0, 8'd0};
    tbl[19] = '{0, 4'd0, 8'h00, 0, 0, 0, 8'h00, 4'd1, 8'h22, 1, 0, 8'd1};
    tbl[20] = '{1, 4'd1, 8'hEE, 0, 0, 1, 8'hFF, 4'd1, 8'h22, 1, 0, 8'd2};
    tbl[21] = '{0, 4'd0, 8'h00, 0, 0, 0, 8'h00, 4'd2, 8'h33, 1, 0, 8'd3};
    tbl[22] = '{0, 4'd0, 8'h00, 0, 0, 1, 8'h03, 4'd6, 8'h5A, 1, 0, 8'd4};
    tbl[23] = '{0, 4'd0, 8'h00, 0, 1, 0, 8'h00, 4'd6, 8'h00, 0, 1, 8'd5};

    model_reset();
    #7;
    chk("reset pc", 32'(PC), 32'd0);
    chk("reset instr", 32'(Instr_Code), 32'd0);
    chk("reset running", 32'(Running), 32'd0);
    chk("reset halted", 32'(Halted), 32'd0);
    chk("reset count", 32'(Instr_Count), 32'd0);
    chk("reset fault", 32'(Fault), 32'd0);
    #5 Reset_n = 1'b1;

    for (int i = 4; i < 16; i++) begin
      le = 1'b1; la = 4'(i); ld = 8'(8'hA0 + i);
      cycle();
      check_model("preload");
    end

    for (int i = 0; i < 24; i++) begin
      le = tbl[i].le; la = tbl[i].la; ld = tbl[i].ld; st = tbl[i].st;
      hr = tbl[i].hr; bt = tbl[i].bt; sev = tbl[i].sev;
      cycle();
      chk($sformatf("vec%0d pc", i), 32'(PC), 32'(tbl[i].pc));
      chk($sformatf("vec%0d instr", i), 32'(Instr_Code), 32'(tbl[i].ic));
      chk($sformatf("vec%0d running", i), 32'(Running), 32'(tbl[i].run));
      chk($sformatf("vec%0d halted", i), 32'(Halted), 32'(tbl[i].hlt));
      chk($sformatf("vec%0d count", i), 32'(Instr_Count), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d fault", i), 32'(Fault), 32'd0);
    end

    for (int i = 0; i < 400; i++) begin
      int tmp;
      st = ($urandom_range(0, 11) == 0);
      le = st ? 1'b0 : ($urandom_range(0, 3) == 0);
      la = 4'($urandom_range(0, 15));
      ld = 8'($urandom_range(0, 255));
      hr = ($urandom_range(0, 9) == 0);
      bt = ($urandom_range(0, 2) == 0);
      tmp = $urandom_range(0, 8);
      sev = $urandom_range(0, 1) ? 8'($urandom_range(0, 255)) : 8'(tmp - 4);
      cycle();
      check_model($sformatf("rand%0d", i));
    end

    // Get to a known RUN at PC=0, then branch-to-self until the counter saturates.
    idle_inputs(); hr = 1'b1; cycle();
    idle_inputs(); st = 1'b1; cycle();
    check_model("restart");
    idle_inputs(); bt = 1'b1; sev = 8'hFF;
    for (int i = 0; i < 300; i++) begin
      cycle();
      if (i % 50 == 0 || i > 250) check_model($sformatf("sat%0d", i));
    end
    chk("sat count", 32'(Instr_Count), 32'hFF);
    chk("sat pc", 32'(PC), 32'd0);

    sev = 8'h0E; cycle();
    chk("to15 pc", 32'(PC), 32'd15);
    check_model("to15");
    idle_inputs(); cycle();
`ifdef PC_WRAP_TRAP_EN
    chk("trap pc", 32'(PC), 32'd15);
    chk("trap fault", 32'(Fault), 32'd1);
    chk("trap halted", 32'(Halted), 32'd1);
`else
    chk("wrap pc", 32'(PC), 32'd0);
    chk("wrap running", 32'(Running), 32'd1);
    chk("wrap fault", 32'(Fault), 32'd0);
`endif
    check_model("wrap");

    idle_inputs(); st = 1'b1; cycle();
    idle_inputs(); cycle(); cycle();
    check_model("prerst");
    #3 Reset_n = 1'b0;
    #1;
    model_reset();
    chk("midrst pc", 32'(PC), 32'd0);
    chk("midrst instr", 32'(Instr_Code), 32'd0);
    chk("midrst running", 32'(Running), 32'd0);
    chk("midrst count", 32'(Instr_Count), 32'd0);
    chk("midrst halted", 32'(Halted), 32'd0);
    #2 Reset_n = 1'b1;
    st = 1'b1; cycle();
    check_model("rerun");
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      cycle();
      check_model($sformatf("rerun%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
